rpn_stack_calc: RTL and testbench

Parametrised reverse-Polish calculator core: a control FSM plus a DEPTH-entry operand stack of WIDTH-bit words and an ALU. It replaces the fixed OpA/OpB/OpCode sequencer. It accepts any number of pushes up to DEPTH, and it executes binary and stack operators on the top entries. It provides single-level undo and reports overflow, underflow and bad-opcode errors. It sits between the debounced button-pulse generators and the display multiplexer / 7-segment driver.

---
 rtl/rpn_stack_calc.sv | 162 ++++++++++++++++
 tb/tb_rpn_stack_calc.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_calc.sv
// Reverse-Polish calculator core: operand stack, ALU and control FSM
// with single-level undo and overflow/underflow/bad-opcode reporting.
module rpn_stack_calc #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enter_pulse,
  input  logic                         op_pulse,
  input  logic                         undo_pulse,
  input  logic [WIDTH-1:0]             data_in,
  input  logic [2:0]                   opcode,
  output logic [WIDTH-1:0]             display_value,
  output logic                         to_display_sel,
  output logic [WIDTH-1:0]             top_value,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [2:0]                   status,
  output logic [1:0]                   error_code,
  output logic                         undo_valid
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_DROP = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_BAD  = 3'd7;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    ENTERING    = 3'd0,
    PUSH        = 3'd1,
    EXEC        = 3'd2,
    SHOW_RESULT = 3'd3,
    ERROR       = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] snap  [DEPTH];
  logic [CW-1:0]    snapCount;
  logic [2:0]       opReg;

  logic [IW-1:0]    topIdx;
  logic [IW-1:0]    secIdx;
  logic [IW-1:0]    pushIdx;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] aluRes;
  logic             opOk;

  assign topIdx  = IW'(count - CW'(1));
  assign secIdx  = IW'(count - CW'(2));
  assign pushIdx = IW'(count);
  assign opA     = stack[secIdx];
  assign opB     = stack[topIdx];

  // Requirement check is done on the live opcode at the sampling edge
  assign opOk = (opcode == OP_DROP) ? (count != '0)
                                    : (count >= CW'(2));

  always_comb begin
    aluRes = opA + opB;
    unique case (opReg)
      OP_SUB:  aluRes = opA - opB;
      OP_AND:  aluRes = opA & opB;
      OP_OR:   aluRes = opA | opB;
      OP_XOR:  aluRes = opA ^ opB;
      default: aluRes = opA + opB;
    endcase
  end

  assign top_value      = (count == '0) ? '0 : stack[topIdx];
  assign to_display_sel = (state == SHOW_RESULT);
  assign display_value  = to_display_sel ? top_value : data_in;
  assign status         = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ENTERING;
      count      <= '0;
      snapCount  <= '0;
      error_code <= 2'd0;
      undo_valid <= 1'b0;
      opReg      <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
        snap[i]  <= '0;
      end
    end else begin
      unique case (state)
        ENTERING, SHOW_RESULT: begin
          if (enter_pulse) begin
            if (count < FULL) begin
              state <= PUSH;
            end else begin
              state      <= ERROR;
              error_code <= 2'd1;
            end
          end else if (op_pulse) begin
            opReg <= opcode;
            if (opcode == OP_BAD) begin
              state      <= ERROR;
              error_code <= 2'd3;
            end else if (opOk) begin
              state <= EXEC;
            end else begin
              state      <= ERROR;
              error_code <= 2'd2;
            end
          end else if (undo_pulse && undo_valid) begin
            stack      <= snap;
            count      <= snapCount;
            undo_valid <= 1'b0;
            state      <= ENTERING;
          end
        end
        PUSH: begin
          snap            <= stack;
          snapCount       <= count;
          undo_valid      <= 1'b1;
          stack[pushIdx]  <= data_in;
          count           <= count + CW'(1);
          state           <= ENTERING;
        end
        EXEC: begin
          snap       <= stack;
          snapCount  <= count;
          undo_valid <= 1'b1;
          unique case (opReg)
            OP_DROP: count <= count - CW'(1);
            OP_SWAP: begin
              stack[secIdx] <= opB;
              stack[topIdx] <= opA;
            end
            default: begin
              stack[secIdx] <= aluRes;
              count         <= count - CW'(1);
            end
          endcase
          state <= SHOW_RESULT;
        end
        ERROR: begin
          // Only a lone undo clears the error; enter/op outrank it
          if (undo_pulse && !enter_pulse && !op_pulse) begin
            error_code <= 2'd0;
            state      <= ENTERING;
          end
        end
        default: state <= ENTERING;
      endcase
    end
  end

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Bench for rpn_stack_calc: directed scenarios plus random pulses
// checked against a queue-based stack model.
module tb_rpn_stack_calc;

  localparam int W = 16;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enter_pulse = 1'b0;
  logic         op_pulse = 1'b0;
  logic         undo_pulse = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [2:0]   opcode = 3'd0;
  logic [W-1:0] display_value;
  logic         to_display_sel;
  logic [W-1:0] top_value;
  logic [2:0]   count;
  logic [2:0]   status;
  logic [1:0]   error_code;
  logic         undo_valid;

  int nCmp = 0;
  int nBad = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] sq[$];
  logic         mUndo;
  logic [1:0]   mErr;
  logic [2:0]   mSt;

  always #5 clock = ~clock;

  rpn_stack_calc #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock),
    .reset(reset),
    .enter_pulse(enter_pulse),
    .op_pulse(op_pulse),
    .undo_pulse(undo_pulse),
    .data_in(data_in),
    .opcode(opcode),
    .display_value(display_value),
    .to_display_sel(to_display_sel),
    .top_value(top_value),
    .count(count),
    .status(status),
    .error_code(error_code),
    .undo_valid(undo_valid)
  );

  function automatic logic [W-1:0] mTop();
    return (mq.size() == 0) ? '0 : mq[mq.size()-1];
  endfunction

  task automatic model_reset();
    mq = {};
    sq = {};
    mUndo = 1'b0;
    mErr = 2'd0;
    mSt = 3'd0;
  endtask

  task automatic model_enter(input logic [W-1:0] v);
    if (mSt == 3'd4) return;
    if (mq.size() < D) begin
      sq = mq;
      mq.push_back(v);
      mUndo = 1'b1;
      mSt = 3'd0;
    end else begin
      mSt = 3'd4;
      mErr = 2'd1;
    end
  endtask

  task automatic model_op(input logic [2:0] op);
    logic [W-1:0] a, b;
    int need;
    if (mSt == 3'd4) return;
    if (op == 3'd7) begin
      mSt = 3'd4;
      mErr = 2'd3;
      return;
    end
    need = (op == 3'd5) ? 1 : 2;
    if (mq.size() < need) begin
      mSt = 3'd4;
      mErr = 2'd2;
      return;
    end
    sq = mq;
    mUndo = 1'b1;
    b = mq.pop_back();
    case (op)
      3'd5: ;
      3'd6: begin
        a = mq.pop_back();
        mq.push_back(b);
        mq.push_back(a);
      end
      default: begin
        a = mq.pop_back();
        case (op)
          3'd0: mq.push_back(a + b);
          3'd1: mq.push_back(a - b);
          3'd2: mq.push_back(a & b);
          3'd3: mq.push_back(a | b);
          default: mq.push_back(a ^ b);
        endcase
      end
    endcase
    mSt = 3'd3;
  endtask

  task automatic model_undo();
    if (mSt == 3'd4) begin
      mSt = 3'd0;
      mErr = 2'd0;
    end else if (mUndo) begin
      mq = sq;
      mUndo = 1'b0;
      mSt = 3'd0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    enter_pulse = 1'b0;
    op_pulse = 1'b0;
    undo_pulse = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
  endtask

  // One pulse cycle, then spacing so the commit has landed
  task automatic act(input logic e, input logic o, input logic u,
                     input logic [W-1:0] v, input logic [2:0] op);
    @(negedge clock);
    data_in = v;
    opcode = op;
    enter_pulse = e;
    op_pulse = o;
    undo_pulse = u;
    @(negedge clock);
    enter_pulse = 1'b0;
    op_pulse = 1'b0;
    undo_pulse = 1'b0;
    @(negedge clock);
    @(negedge clock);
    if (e) model_enter(v);
    else if (o) model_op(op);
    else if (u) model_undo();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    data_in = 16'h1234;
    #12;
    nCmp++; if (status !== 3'd0) begin nBad++; $display("FAIL rst_status got %0d want 0", status); end
    nCmp++; if (count !== 3'd0) begin nBad++; $display("FAIL rst_count got %0d want 0", count); end
    nCmp++; if (top_value !== '0) begin nBad++; $display("FAIL rst_top got %h want 0", top_value); end
    nCmp++; if (error_code !== 2'd0) begin nBad++; $display("FAIL rst_err got %0d want 0", error_code); end
    nCmp++; if (undo_valid !== 1'b0) begin nBad++; $display("FAIL rst_undo got %b want 0", undo_valid); end
    nCmp++; if (to_display_sel !== 1'b0) begin nBad++; $display("FAIL rst_sel got %b want 0", to_display_sel); end
    nCmp++; if (display_value !== 16'h1234) begin nBad++; $display("FAIL rst_disp got %h want 1234", display_value); end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_add();
    do_reset();
    act(1, 0, 0, 16'h0003, 3'd0);
    act(1, 0, 0, 16'h0005, 3'd0);
    @(negedge clock);
    opcode = 3'd0;
    op_pulse = 1'b1;
    @(negedge clock);
    op_pulse = 1'b0;
    nCmp++; if (status !== 3'd2) begin nBad++; $display("FAIL add_exec_status got %0d want 2", status); end
    nCmp++; if (count !== 3'd2) begin nBad++; $display("FAIL add_pre_count got %0d want 2", count); end
    @(negedge clock);
    model_op(3'd0);
    nCmp++; if (count !== 3'd1) begin nBad++; $display("FAIL add_count got %0d want 1", count); end
    nCmp++; if (top_value !== 16'h0008) begin nBad++; $display("FAIL add_top got %h want 0008", top_value); end
    nCmp++; if (status !== 3'd3) begin nBad++; $display("FAIL add_status got %0d want 3", status); end
    nCmp++; if (to_display_sel !== 1'b1) begin nBad++; $display("FAIL add_sel got %b want 1", to_display_sel); end
    nCmp++; if (display_value !== 16'h0008) begin nBad++; $display("FAIL add_disp got %h want 0008", display_value); end
  endtask

  task automatic test_sub();
    do_reset();
    act(1, 0, 0, 16'h0002, 3'd0);
    act(1, 0, 0, 16'h0005, 3'd0);
    act(0, 1, 0, 16'h0000, 3'd1);
    nCmp++; if (top_value !== 16'hFFFD) begin nBad++; $display("FAIL sub_top got %h want fffd", top_value); end
    nCmp++; if (count !== 3'd1) begin nBad++; $display("FAIL sub_count got %0d want 1", count); end
  endtask

  task automatic test_overflow_undo();
    do_reset();
    for (int i = 1; i <= 4; i++) act(1, 0, 0, W'(i), 3'd0);
    act(1, 0, 0, 16'h0055, 3'd0);
    nCmp++; if (status !== 3'd4) begin nBad++; $display("FAIL ovf_status got %0d want 4", status); end
    nCmp++; if (error_code !== 2'd1) begin nBad++; $display("FAIL ovf_err got %0d want 1", error_code); end
    nCmp++; if (count !== 3'd4) begin nBad++; $display("FAIL ovf_count got %0d want 4", count); end
    nCmp++; if (top_value !== 16'h0004) begin nBad++; $display("FAIL ovf_top got %h want 0004", top_value); end
    act(1, 0, 0, 16'h0066, 3'd0);
    nCmp++; if (error_code !== 2'd1) begin nBad++; $display("FAIL ovf_hold got %0d want 1", error_code); end
    act(0, 0, 1, 16'h0000, 3'd0);
    nCmp++; if (status !== 3'd0) begin nBad++; $display("FAIL ovf_undo_status got %0d want 0", status); end
    nCmp++; if (error_code !== 2'd0) begin nBad++; $display("FAIL ovf_undo_err got %0d want 0", error_code); end
    nCmp++; if (count !== 3'd4 || top_value !== 16'h0004) begin nBad++; $display("FAIL ovf_intact got %0d/%h want 4/0004", count, top_value); end
    nCmp++; if (undo_valid !== 1'b1) begin nBad++; $display("FAIL ovf_undo_valid got %b want 1", undo_valid); end
  endtask

  task automatic test_underflow_badop();
    do_reset();
    act(1, 0, 0, 16'h0007, 3'd0);
    act(0, 1, 0, 16'h0000, 3'd0);
    nCmp++; if (error_code !== 2'd2) begin nBad++; $display("FAIL udf_err got %0d want 2", error_code); end
    nCmp++; if (status !== 3'd4) begin nBad++; $display("FAIL udf_status got %0d want 4", status); end
    act(0, 0, 1, 16'h0000, 3'd0);
    act(1, 0, 0, 16'h0009, 3'd0);
    act(0, 1, 0, 16'h0000, 3'd7);
    nCmp++; if (error_code !== 2'd3) begin nBad++; $display("FAIL bad_err got %0d want 3", error_code); end
    nCmp++; if (count !== 3'd2) begin nBad++; $display("FAIL bad_count got %0d want 2", count); end
  endtask

  task automatic test_swap_undo();
    do_reset();
    act(1, 0, 0, 16'h000A, 3'd0);
    act(1, 0, 0, 16'h000B, 3'd0);
    act(0, 1, 0, 16'h0000, 3'd6);
    nCmp++; if (top_value !== 16'h000A) begin nBad++; $display("FAIL swap_top got %h want 000a", top_value); end
    act(0, 0, 1, 16'h0000, 3'd0);
    nCmp++; if (top_value !== 16'h000B) begin nBad++; $display("FAIL swap_undo_top got %h want 000b", top_value); end
    nCmp++; if (undo_valid !== 1'b0) begin nBad++; $display("FAIL swap_undo_valid got %b want 0", undo_valid); end
    act(0, 0, 1, 16'h0000, 3'd0);
    nCmp++; if (top_value !== 16'h000B || count !== 3'd2) begin nBad++; $display("FAIL undo2 got %h/%0d want 000b/2", top_value, count); end
    nCmp++; if (status !== 3'd0) begin nBad++; $display("FAIL undo2_status got %0d want 0", status); end
  endtask

  task automatic test_priority_reset_exec();
    do_reset();
    act(1, 0, 0, 16'h0011, 3'd0);
    act(1, 0, 1, 16'h0022, 3'd0);
    nCmp++; if (count !== 3'd2 || top_value !== 16'h0022) begin nBad++; $display("FAIL prio got %0d/%h want 2/0022", count, top_value); end
    @(negedge clock);
    opcode = 3'd0;
    op_pulse = 1'b1;
    @(negedge clock);
    op_pulse = 1'b0;
    data_in = 16'h0abc;
    #1 reset = 1'b0;
    #1;
    nCmp++; if (count !== 3'd0) begin nBad++; $display("FAIL rexec_count got %0d want 0", count); end
    nCmp++; if (status !== 3'd0) begin nBad++; $display("FAIL rexec_status got %0d want 0", status); end
    nCmp++; if (top_value !== '0) begin nBad++; $display("FAIL rexec_top got %h want 0", top_value); end
    nCmp++; if (undo_valid !== 1'b0 || error_code !== 2'd0) begin nBad++; $display("FAIL rexec_flags got %b/%0d want 0/0", undo_valid, error_code); end
    nCmp++; if (display_value !== 16'h0abc) begin nBad++; $display("FAIL rexec_disp got %h want 0abc", display_value); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    nCmp++; if (count !== 3'd0 || status !== 3'd0) begin nBad++; $display("FAIL rexec_post got %0d/%0d want 0/0", count, status); end
  endtask

  task automatic test_random();
    logic e, o, u;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      e = ($urandom_range(0, 2) == 0);
      o = ($urandom_range(0, 1) == 0);
      u = ($urandom_range(0, 3) == 0);
      act(e, o, u, W'($urandom), 3'($urandom));
      nCmp++; if (status !== mSt) begin nBad++; $display("FAIL rnd_status[%0d] got %0d want %0d", i, status, mSt); end
      nCmp++; if (count !== 3'(mq.size())) begin nBad++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, mq.size()); end
      nCmp++; if (top_value !== mTop()) begin nBad++; $display("FAIL rnd_top[%0d] got %h want %h", i, top_value, mTop()); end
      nCmp++; if (error_code !== mErr) begin nBad++; $display("FAIL rnd_err[%0d] got %0d want %0d", i, error_code, mErr); end
      nCmp++; if (undo_valid !== mUndo) begin nBad++; $display("FAIL rnd_undo[%0d] got %b want %b", i, undo_valid, mUndo); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_sub();
    test_overflow_undo();
    test_underflow_badop();
    test_swap_undo();
    test_priority_reset_exec();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
